// File: rtl/cart_bus_pkg.sv
// Shared types for the cartridge bus scheduler: FSM encoding, grant owner, activity codes, defaults.
// Latency: none (package only).
// Backpressure: none (package only).
package cart_bus_pkg;

    localparam int M2_DIV_DEF     = 6;
    localparam int CHR_CYCLES_DEF = 4;
    localparam int ACT_HOLD_DEF   = 4095;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRG_SETUP   = 3'd1,
        ST_PRG_ACCESS  = 3'd2,
        ST_CHR_STROBE  = 3'd3,
        ST_CHR_RECOVER = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_PRG = 1'b0,
        GRANT_CHR = 1'b1
    } grant_t;

    typedef logic [1:0] act_code_t;

    localparam act_code_t ACT_PRG_RD = 2'b00;
    localparam act_code_t ACT_PRG_WR = 2'b01;
    localparam act_code_t ACT_CHR_RD = 2'b10;
    localparam act_code_t ACT_CHR_WR = 2'b11;

    // Activity code for a completed access; rw is 1 for read.
    function automatic act_code_t act_code_of(input logic is_chr, input logic rw);
        act_code_t code;
        case ({is_chr, rw})
            2'b01:   code = ACT_PRG_RD;
            2'b00:   code = ACT_PRG_WR;
            2'b11:   code = ACT_CHR_RD;
            default: code = ACT_CHR_WR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cart_bus_scheduler_if.sv
// Request/ack handshake and cartridge bus strobes of the scheduler, grouped as one bundle.
// Latency: none (wiring only).
// Backpressure: requests are level-held by the master until the one-cycle ack.
interface cart_bus_scheduler_if;
    import cart_bus_pkg::*;

    logic      prg_req;
    logic      prg_rw;
    logic      prg_ack;
    logic      chr_req;
    logic      chr_rw;
    logic      chr_ack;
    logic      m2;
    logic      cpu_rw;
    logic      cpu_oe;
    logic      romsel_en;
    logic      ppu_rd;
    logic      ppu_wr;
    logic      ppu_oe;
    act_code_t act_code;
    logic      act_valid;

    modport slave (
        input  prg_req, prg_rw, chr_req, chr_rw,
        output prg_ack, chr_ack, m2, cpu_rw, cpu_oe, romsel_en,
        output ppu_rd, ppu_wr, ppu_oe, act_code, act_valid
    );

    modport master (
        output prg_req, prg_rw, chr_req, chr_rw,
        input  prg_ack, chr_ack, m2, cpu_rw, cpu_oe, romsel_en,
        input  ppu_rd, ppu_wr, ppu_oe, act_code, act_valid
    );

endinterface

// File: rtl/m2_divider.sv
// M2 phase generator: modulo-M2_DIV counter toggling m2 on wrap, plus look-ahead phase strobes.
// Latency: strobes are high in the clock before the edge they describe.
// Backpressure: none, free-running.
module m2_divider
    import cart_bus_pkg::*;
#(
    parameter int M2_DIV = M2_DIV_DEF
) (
    input  logic master_clock,
    input  logic nreset,
    output logic m2,
    output logic win_start,
    output logic rise_next,
    output logic last_high_next
);

    logic [4:0] cnt;
    logic       started;
    logic       half_end;

    // The first edge after reset only arms the divider, so the clock it opens
    // keeps the reset phase (counter 0, m2 low) and is therefore a PRG window.
    assign half_end       = started && (cnt == 5'(M2_DIV - 1));
    assign win_start      = !started || (half_end && m2);
    assign rise_next      = half_end && !m2;
    assign last_high_next = started && m2 && (cnt == 5'(M2_DIV - 2));

    // Phase counter and m2 flop.
    always_ff @(posedge master_clock or negedge nreset) begin
        if (!nreset) begin
            cnt     <= '0;
            m2      <= 1'b0;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (half_end) begin
            cnt <= '0;
            m2  <= ~m2;
        end else begin
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/cart_bus_scheduler.sv
// Cartridge bus scheduler: alternates CPU (PRG) and PPU (CHR) accesses around a generated M2 clock.
// Latency: PRG starts on an M2-low window and acks 2*M2_DIV-1 clocks later; CHR starts on the sampling edge, acks after CHR_CYCLES.
// Backpressure: requests are level-held until the one-cycle ack; a started access always completes.
module cart_bus_scheduler
    import cart_bus_pkg::*;
#(
    parameter int M2_DIV     = M2_DIV_DEF,
    parameter int CHR_CYCLES = CHR_CYCLES_DEF,
    parameter int ACT_HOLD   = ACT_HOLD_DEF
) (
    input  logic                master_clock,
    input  logic                nreset,
    cart_bus_scheduler_if.slave bus
);

    localparam int HW = $clog2(ACT_HOLD + 1);

    logic      m2;
    logic      win_start;
    logic      rise_next;
    logic      last_high_next;

    state_t    state, state_nxt;
    grant_t    last_grant, grant_nxt;
    logic      lat_rw, rw_nxt;
    logic [3:0] cyc, cyc_nxt;

    logic      prg_ok, chr_ok;
    logic      prg_ack_nxt, chr_ack_nxt;
    logic      cpu_act, ppu_act;

    logic      cpu_rw_q, cpu_oe_q, romsel_q;
    logic      ppu_rd_q, ppu_wr_q, ppu_oe_q;
    logic      prg_ack_q, chr_ack_q;
    act_code_t act_code_q;
    logic      act_valid_q;
    logic [HW-1:0] hold_q;

    m2_divider #(.M2_DIV(M2_DIV)) u_div (
        .master_clock   (master_clock),
        .nreset         (nreset),
        .m2             (m2),
        .win_start      (win_start),
        .rise_next      (rise_next),
        .last_high_next (last_high_next)
    );

    // FSM state, grant history, latched direction and CHR strobe counter.
    always_ff @(posedge master_clock or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_CHR;
            lat_rw     <= 1'b1;
            cyc        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            lat_rw     <= rw_nxt;
            cyc        <= cyc_nxt;
        end
    end

    // Arbitration and next-state: under contention the side that did not win
    // last has priority, so a waiting PRG also blocks new CHR until its window.
    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        rw_nxt    = lat_rw;
        cyc_nxt   = cyc;
        prg_ok    = win_start && bus.prg_req && (!bus.chr_req || last_grant == GRANT_CHR);
        chr_ok    = bus.chr_req && !prg_ok && !(bus.prg_req && last_grant == GRANT_CHR);

        case (state)
            ST_IDLE: begin
                if (prg_ok) begin
                    state_nxt = ST_PRG_SETUP;
                    grant_nxt = GRANT_PRG;
                    rw_nxt    = bus.prg_rw;
                end else if (chr_ok) begin
                    state_nxt = ST_CHR_STROBE;
                    grant_nxt = GRANT_CHR;
                    rw_nxt    = bus.chr_rw;
                    cyc_nxt   = 4'(CHR_CYCLES - 1);
                end
            end
            ST_PRG_SETUP: begin
                if (rise_next) state_nxt = ST_PRG_ACCESS;
            end
            ST_PRG_ACCESS: begin
                if (win_start) state_nxt = ST_IDLE;
            end
            ST_CHR_STROBE: begin
                if (cyc == '0) state_nxt = ST_CHR_RECOVER;
                else           cyc_nxt   = cyc - 4'd1;
            end
            ST_CHR_RECOVER: state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase

        prg_ack_nxt = (state == ST_PRG_ACCESS) && last_high_next;
        chr_ack_nxt = (state_nxt == ST_CHR_STROBE) && (cyc_nxt == '0);
        cpu_act     = (state_nxt == ST_PRG_SETUP) || (state_nxt == ST_PRG_ACCESS);
        ppu_act     = (state_nxt == ST_CHR_STROBE);
    end

    // Registered bus strobes, acks and activity reporting (all drop at once on reset).
    always_ff @(posedge master_clock or negedge nreset) begin
        if (!nreset) begin
            cpu_rw_q    <= 1'b1;
            cpu_oe_q    <= 1'b1;
            romsel_q    <= 1'b0;
            ppu_rd_q    <= 1'b1;
            ppu_wr_q    <= 1'b1;
            ppu_oe_q    <= 1'b1;
            prg_ack_q   <= 1'b0;
            chr_ack_q   <= 1'b0;
            act_code_q  <= ACT_PRG_RD;
            act_valid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            cpu_rw_q  <= cpu_act ? rw_nxt : 1'b1;
            cpu_oe_q  <= !cpu_act;
            romsel_q  <= (state_nxt == ST_PRG_ACCESS);
            ppu_rd_q  <= !(ppu_act && rw_nxt);
            ppu_wr_q  <= !(ppu_act && !rw_nxt);
            ppu_oe_q  <= !ppu_act;
            prg_ack_q <= prg_ack_nxt;
            chr_ack_q <= chr_ack_nxt;
            if (prg_ack_nxt || chr_ack_nxt) begin
                act_code_q  <= act_code_of(chr_ack_nxt, rw_nxt);
                act_valid_q <= 1'b1;
                hold_q      <= HW'(ACT_HOLD - 1);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end else begin
                act_valid_q <= 1'b0;
            end
        end
    end

    assign bus.m2        = m2;
    assign bus.cpu_rw    = cpu_rw_q;
    assign bus.cpu_oe    = cpu_oe_q;
    assign bus.romsel_en = romsel_q;
    assign bus.ppu_rd    = ppu_rd_q;
    assign bus.ppu_wr    = ppu_wr_q;
    assign bus.ppu_oe    = ppu_oe_q;
    assign bus.prg_ack   = prg_ack_q;
    assign bus.chr_ack   = chr_ack_q;
    assign bus.act_code  = act_code_q;
    assign bus.act_valid = act_valid_q;

endmodule

// File: tb/tb_cart_bus_scheduler.sv
// Directed bench for cart_bus_scheduler: per-clock vector tables plus hand sequences for multi-cycle cases.
// Latency: clock k is the k-th rising edge after reset release; outputs are sampled 1 time unit after it.
// Backpressure: requests are held or dropped explicitly by each sequence.
module tb_cart_bus_scheduler;
    import cart_bus_pkg::*;

    localparam int M2_DIV     = 6;
    localparam int CHR_CYCLES = 4;
    localparam int ACT_HOLD   = 10;

    logic master_clock = 1'b0;
    logic nreset       = 1'b0;

    cart_bus_scheduler_if bus();

    cart_bus_scheduler #(
        .M2_DIV     (M2_DIV),
        .CHR_CYCLES (CHR_CYCLES),
        .ACT_HOLD   (ACT_HOLD)
    ) dut (
        .master_clock (master_clock),
        .nreset       (nreset),
        .bus          (bus)
    );

    always #5 master_clock = ~master_clock;

    typedef struct packed {
        logic       m2;
        logic       cpu_rw;
        logic       cpu_oe;
        logic       romsel_en;
        logic       prg_ack;
        logic       ppu_rd;
        logic       ppu_wr;
        logic       ppu_oe;
        logic       chr_ack;
        logic       act_valid;
        logic [1:0] act_code;
    } obs_t;

    typedef struct {
        bit   rst;
        bit   prg_req;
        bit   prg_rw;
        bit   chr_req;
        bit   chr_rw;
        obs_t exp;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   overlaps = 0;

    function automatic obs_t ob(bit m2, bit crw, bit coe, bit rom, bit pa, bit rd, bit wr,
                                bit poe, bit ca, bit av, bit [1:0] code);
        obs_t o;
        o.m2 = m2; o.cpu_rw = crw; o.cpu_oe = coe; o.romsel_en = rom; o.prg_ack = pa;
        o.ppu_rd = rd; o.ppu_wr = wr; o.ppu_oe = poe; o.chr_ack = ca;
        o.act_valid = av; o.act_code = code;
        return o;
    endfunction

    function automatic obs_t sample();
        return ob(bus.m2, bus.cpu_rw, bus.cpu_oe, bus.romsel_en, bus.prg_ack, bus.ppu_rd,
                  bus.ppu_wr, bus.ppu_oe, bus.chr_ack, bus.act_valid, bus.act_code);
    endfunction

    task automatic add_vec(bit rst, bit pr, bit prw, bit cr, bit crw, obs_t exp);
        vec_t v;
        v.rst = rst; v.prg_req = pr; v.prg_rw = prw; v.chr_req = cr; v.chr_rw = crw; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic check_obs(input string nm, input int idx, input obs_t exp);
        obs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%b required=%b (m2 crw coe rom pack rd wr poe cack av code)",
                     nm, idx, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge master_clock);
        #1;
        if ((!bus.cpu_oe || bus.romsel_en) && (!bus.ppu_oe || !bus.ppu_rd || !bus.ppu_wr))
            overlaps++;
    endtask

    task automatic do_reset();
        nreset      = 1'b0;
        bus.prg_req = 1'b0;
        bus.prg_rw  = 1'b1;
        bus.chr_req = 1'b0;
        bus.chr_rw  = 1'b1;
        repeat (2) @(posedge master_clock);
        #2 nreset = 1'b1;
    endtask

    initial begin
        obs_t rst_obs;
        int   kinds[$];
        int   clks[$];
        int   codes[$];
        int   exp_kind[4];
        int   exp_clk[4];
        int   exp_code[4];
        int   acks, first_oe, first_rom, first_ack, first_rd;

        rst_obs = ob(0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 2'b00);

        // PRG read held from reset release: setup clocks 0-5, access 6-11, ack on 11.
        for (int k = 0; k <= 12; k++)
            add_vec(k == 0, k < 12, 1'b1, 1'b0, 1'b1,
                    ob(k >= 6 && k <= 11, 1, k > 11, k >= 6 && k <= 11, k == 11,
                       1, 1, 1, 0, k >= 11, 2'b00));
        // CHR write sampled on clock 2, request dropped and rw flipped afterwards.
        for (int k = 0; k <= 15; k++)
            add_vec(k == 0, 1'b0, 1'b1, k == 2, k != 2,
                    ob(k >= 6 && k <= 11, 1, 1, 0, 0, 1, !(k >= 2 && k <= 5),
                       !(k >= 2 && k <= 5), k == 5, k >= 5 && k <= 14,
                       (k >= 5) ? 2'b11 : 2'b00));

        // Reset state.
        bus.prg_req = 1'b1; bus.prg_rw = 1'b0; bus.chr_req = 1'b1; bus.chr_rw = 1'b0;
        nreset = 1'b0;
        repeat (2) @(posedge master_clock);
        #1 check_obs("reset_state", 0, rst_obs);

        // Table-driven per-clock vectors.
        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            bus.prg_req = vq[i].prg_req;
            bus.prg_rw  = vq[i].prg_rw;
            bus.chr_req = vq[i].chr_req;
            bus.chr_rw  = vq[i].chr_rw;
            step();
            check_obs("vec", i, vq[i].exp);
        end

        // Both requests held: grants must alternate PRG, CHR, PRG, CHR.
        do_reset();
        bus.prg_req = 1'b1; bus.chr_req = 1'b1; bus.prg_rw = 1'b1; bus.chr_rw = 1'b1;
        for (int c = 0; c < 120 && kinds.size() < 4; c++) begin
            step();
            if (bus.prg_ack) begin kinds.push_back(0); clks.push_back(c); codes.push_back(int'(bus.act_code)); end
            if (bus.chr_ack) begin kinds.push_back(1); clks.push_back(c); codes.push_back(int'(bus.act_code)); end
        end
        exp_kind = '{0, 1, 0, 1};
        exp_clk  = '{11, 16, 35, 40};
        exp_code = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            check_int($sformatf("arb_kind%0d", i), (i < kinds.size()) ? kinds[i] : -1, exp_kind[i]);
            check_int($sformatf("arb_clock%0d", i), (i < clks.size()) ? clks[i] : -1, exp_clk[i]);
            check_int($sformatf("arb_code%0d", i), (i < codes.size()) ? codes[i] : -1, exp_code[i]);
        end

        // Reset asserted in PRG_ACCESS clock 8 of a write: strobes drop at once, no ack.
        do_reset();
        bus.prg_req = 1'b1; bus.prg_rw = 1'b0;
        acks = 0;
        for (int c = 0; c <= 8; c++) begin
            step();
            if (bus.prg_ack) acks++;
        end
        check_obs("abort_before", 8, ob(1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 2'b00));
        nreset = 1'b0;
        #1 check_obs("abort_release", 0, rst_obs);
        repeat (2) @(posedge master_clock);
        #1 check_obs("abort_hold", 0, rst_obs);
        #1 nreset = 1'b1;
        first_oe = -1; first_rom = -1; first_ack = -1;
        for (int c = 0; c <= 14; c++) begin
            step();
            if (!bus.cpu_oe && first_oe < 0)   first_oe  = c;
            if (bus.romsel_en && first_rom < 0) first_rom = c;
            if (bus.prg_ack && first_ack < 0)   first_ack = c;
        end
        check_int("abort_acks", acks, 0);
        check_int("restart_setup_clock", first_oe, 0);
        check_int("restart_access_clock", first_rom, 6);
        check_int("restart_ack_clock", first_ack, 11);

        // PRG arriving while CHR covers the clock-12 window waits for clock 24.
        do_reset();
        first_rd = -1; first_oe = -1; first_ack = -1;
        for (int c = 0; c <= 30; c++) begin
            bus.chr_req = (c == 10);
            bus.chr_rw  = 1'b1;
            bus.prg_req = (c >= 11);
            bus.prg_rw  = 1'b1;
            step();
            if (!bus.ppu_rd && first_rd < 0)  first_rd  = c;
            if (bus.chr_ack && first_ack < 0) first_ack = c;
            if (!bus.cpu_oe && first_oe < 0)  first_oe  = c;
        end
        check_int("late_prg_chr_start", first_rd, 10);
        check_int("late_prg_chr_ack", first_ack, 13);
        check_int("late_prg_setup_clock", first_oe, 24);

        check_int("cpu_ppu_strobe_overlap", overlaps, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
